// File: rtl/regfile_snapshot.sv
// Purpose:  shadow register file mirroring writebacks; streams a snapshot per commit (full or dirty-only).
// Latency:  commit in cycle T -> first beat valid in T+1; every output is registered.
// Backpress: out_ready low stalls the beat with fields held; writebacks during a snapshot queue in a FIFO.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   wb_en/wb_addr/wb_data   writeback from the core
//   commit_valid/commit_pc  retirement event and its PC
//   out_valid/out_ready     snapshot beat handshake
//   out_idx/out_data/out_pc/out_last  beat payload
//   busy, drop_cnt, pend_ovf          status

module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [W-1:0]               pop_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic          do_push, do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    // A full FIFO still accepts a push when the same cycle pops a slot free.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end
endmodule

module regfile_snapshot #(
    parameter int XLEN       = 64,
    parameter int NREG       = 32,
    parameter int AW         = $clog2(NREG),
    parameter int DIRTY_ONLY = 0,
    parameter int PEND_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            commit_valid,
    input  logic [XLEN-1:0] commit_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [AW-1:0]   out_idx,
    output logic [XLEN-1:0] out_data,
    output logic [XLEN-1:0] out_pc,
    output logic            out_last,
    output logic            busy,
    output logic [15:0]     drop_cnt,
    output logic            pend_ovf
);
    localparam int CW = $clog2(PEND_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
    state_t state;

    logic [XLEN-1:0] shadow [NREG];
    logic [NREG-1:0] dirty, dirty_nxt;

    function automatic logic [AW-1:0] lowest(input logic [NREG-1:0] v);
        logic [AW-1:0] r;
        r = '0;
        for (int i = NREG - 1; i >= 0; i--)
            if (v[i]) r = AW'(i);
        return r;
    endfunction

    function automatic logic [NREG-1:0] bit_of(input logic [AW-1:0] idx);
        return NREG'(1) << idx;
    endfunction

    // Pending-write FIFO
    logic               push, pop, push_acc, fifo_full, fifo_empty;
    logic [CW-1:0]      fifo_cnt, cnt_nxt;
    logic [AW+XLEN-1:0] pop_dat;
    logic [AW-1:0]      pop_addr;
    logic [XLEN-1:0]    pop_data;

    assign push     = wb_en && (state != IDLE);
    assign pop      = (state == DRAIN) && !fifo_empty;
    assign push_acc = push && (!fifo_full || pop);
    assign cnt_nxt  = fifo_cnt + CW'(push_acc) - CW'(pop);
    assign {pop_addr, pop_data} = pop_dat;

    sync_fifo #(.W(AW + XLEN), .DEPTH(PEND_DEPTH)) u_pend (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat ({wb_addr, wb_data}),
        .pop      (pop),
        .pop_dat  (pop_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    // Single shadow write port: live writeback in IDLE, FIFO replay in DRAIN.
    // The shadow never changes during SCAN, which is what keeps a snapshot consistent.
    logic            wb_ok, hs, sh_we;
    logic [AW-1:0]   sh_addr;
    logic [XLEN-1:0] sh_data;

    assign wb_ok = wb_en && (wb_addr != '0) && (int'(wb_addr) < NREG);
    assign hs    = out_valid && out_ready;

    always_comb begin
        sh_we   = 1'b0;
        sh_addr = '0;
        sh_data = '0;
        if (state == IDLE && wb_ok) begin
            sh_we   = 1'b1;
            sh_addr = wb_addr;
            sh_data = wb_data;
        end else if (pop && pop_addr != '0 && int'(pop_addr) < NREG) begin
            sh_we   = 1'b1;
            sh_addr = pop_addr;
            sh_data = pop_data;
        end
    end

    // Clear first, then set, so a simultaneous set wins.
    always_comb begin
        dirty_nxt = dirty;
        if (DIRTY_ONLY != 0 && state == SCAN && hs) dirty_nxt = dirty_nxt & ~bit_of(out_idx);
        if (sh_we) dirty_nxt = dirty_nxt | bit_of(sh_addr);
    end

    // First beat (at commit) and following beat (after a handshake).
    logic [NREG-1:0] cmask, rem;
    logic [AW-1:0]   start_idx, next_idx;
    logic            start_last, next_last;
    logic [XLEN-1:0] start_data, next_data;

    always_comb begin
        cmask = dirty | (wb_ok ? bit_of(wb_addr) : '0);
        rem   = dirty & ~bit_of(out_idx);
        if (DIRTY_ONLY != 0) begin
            // An empty mask yields idx 0 with last set, and x0 always reads 0.
            start_idx  = lowest(cmask);
            start_last = ((cmask & ~bit_of(start_idx)) == '0);
            next_idx   = lowest(rem);
            next_last  = ((rem & ~bit_of(next_idx)) == '0);
        end else begin
            start_idx  = '0;
            start_last = (NREG == 1);
            next_idx   = out_idx + 1'b1;
            next_last  = (int'(next_idx) == NREG - 1);
        end
        // A writeback in the commit cycle lands in the shadow at the same edge; bypass it.
        start_data = (wb_ok && wb_addr == start_idx) ? wb_data : shadow[start_idx];
        next_data  = shadow[next_idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) shadow[i] <= '0;
            dirty <= '0;
        end else begin
            if (sh_we) shadow[sh_addr] <= sh_data;
            dirty <= dirty_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
            out_pc    <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            drop_cnt  <= '0;
            pend_ovf  <= 1'b0;
        end else begin
            if (push && fifo_full && !pop) pend_ovf <= 1'b1;
            if (commit_valid && state != IDLE && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;

            case (state)
                IDLE: begin
                    if (commit_valid) begin
                        state     <= SCAN;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        out_pc    <= commit_pc;
                        out_idx   <= start_idx;
                        out_data  <= start_data;
                        out_last  <= start_last;
                    end
                end
                SCAN: begin
                    if (hs) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            state     <= (cnt_nxt != '0) ? DRAIN : IDLE;
                            busy      <= (cnt_nxt != '0);
                        end else begin
                            out_idx  <= next_idx;
                            out_data <= next_data;
                            out_last <= next_last;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt_nxt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_snapshot.sv
module tb_regfile_snapshot;
    logic        clk;
    logic        rst_n, wb_en, commit_valid, out_ready;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data, commit_pc;

    // dut0: full-file mode, dut1: dirty-only mode; both share stimulus.
    logic        v0, l0, b0, po0, v1, l1, b1, po1;
    logic [4:0]  i0, i1;
    logic [63:0] d0, p0, d1, p1;
    logic [15:0] dc0, dc1;

    int tests = 0;
    int fails = 0;

    regfile_snapshot #(.XLEN(64), .NREG(32), .DIRTY_ONLY(0), .PEND_DEPTH(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .commit_valid(commit_valid), .commit_pc(commit_pc),
        .out_valid(v0), .out_ready(out_ready), .out_idx(i0), .out_data(d0), .out_pc(p0),
        .out_last(l0), .busy(b0), .drop_cnt(dc0), .pend_ovf(po0));

    regfile_snapshot #(.XLEN(64), .NREG(32), .DIRTY_ONLY(1), .PEND_DEPTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .commit_valid(commit_valid), .commit_pc(commit_pc),
        .out_valid(v1), .out_ready(out_ready), .out_idx(i1), .out_data(d1), .out_pc(p1),
        .out_last(l1), .busy(b1), .drop_cnt(dc1), .pend_ovf(po1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [63:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        step();
        wb_en = 1'b0;
    endtask

    task automatic commit(input logic [63:0] pc);
        commit_valid = 1'b1; commit_pc = pc;
        step();
        commit_valid = 1'b0;
    endtask

    initial begin
        logic done;
        rst_n = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        commit_valid = 1'b0; commit_pc = '0; out_ready = 1'b1;
        step();
        step();

        // Reset state
        chk("rst_valid", 64'(v0), 64'd0);
        chk("rst_idx",   64'(i0), 64'd0);
        chk("rst_data",  d0, 64'd0);
        chk("rst_pc",    p0, 64'd0);
        chk("rst_last",  64'(l0), 64'd0);
        chk("rst_busy",  64'(b0), 64'd0);
        chk("rst_drop",  64'(dc0), 64'd0);
        chk("rst_ovf",   64'(po0), 64'd0);
        rst_n = 1'b1;

        // Full stream, no backpressure
        wr(5'd5, 64'hDEAD);
        commit(64'h8000_0000);
        chk("full_busy", 64'(b0), 64'd1);
        for (int k = 0; k < 32; k++) begin
            chk("full_valid", 64'(v0), 64'd1);
            chk("full_idx",   64'(i0), 64'(k));
            chk("full_data",  d0, (k == 5) ? 64'hDEAD : 64'd0);
            chk("full_last",  64'(l0), (k == 31) ? 64'd1 : 64'd0);
            chk("full_pc",    p0, 64'h8000_0000);
            step();
        end
        chk("full_end_valid", 64'(v0), 64'd0);
        chk("full_end_busy",  64'(b0), 64'd0);

        // Dirty-only mode
        do_reset();
        wr(5'd3, 64'd1);
        wr(5'd17, 64'd2);
        commit(64'h40);
        chk("dirty_b0_valid", 64'(v1), 64'd1);
        chk("dirty_b0_idx",   64'(i1), 64'd3);
        chk("dirty_b0_data",  d1, 64'd1);
        chk("dirty_b0_last",  64'(l1), 64'd0);
        step();
        chk("dirty_b1_idx",   64'(i1), 64'd17);
        chk("dirty_b1_data",  d1, 64'd2);
        chk("dirty_b1_last",  64'(l1), 64'd1);
        step();
        chk("dirty_end_valid", 64'(v1), 64'd0);
        commit(64'h44);
        chk("dirty_empty_valid", 64'(v1), 64'd1);
        chk("dirty_empty_idx",   64'(i1), 64'd0);
        chk("dirty_empty_data",  d1, 64'd0);
        chk("dirty_empty_last",  64'(l1), 64'd1);
        step();
        chk("dirty_empty_end", 64'(v1), 64'd0);

        // Snapshot isolation
        do_reset();
        wr(5'd7, 64'h55);
        commit(64'h100);
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 64'hAA; commit_valid = 1'b1;
        step();
        wb_en = 1'b0;
        step();
        commit_valid = 1'b0;
        for (int k = 2; k < 32; k++) begin
            chk("iso_idx", 64'(i0), 64'(k));
            if (k == 7) chk("iso_x7_old", d0, 64'h55);
            step();
        end
        chk("iso_drain_busy", 64'(b0), 64'd1);
        chk("iso_drain_valid", 64'(v0), 64'd0);
        chk("iso_drop", 64'(dc0), 64'd2);
        step();
        chk("iso_drain_1cyc", 64'(b0), 64'd0);
        commit(64'h200);
        chk("iso2_pc", p0, 64'h200);
        for (int k = 0; k < 7; k++) step();
        chk("iso2_idx", 64'(i0), 64'd7);
        chk("iso2_x7_new", d0, 64'hAA);

        // x0 write and backpressure 1,0,0,1
        do_reset();
        wr(5'd0, 64'hFFFF);
        wr(5'd1, 64'h11);
        commit(64'h300);
        chk("x0_idx",  64'(i0), 64'd0);
        chk("x0_data", d0, 64'd0);
        out_ready = 1'b1; step();
        chk("bp_a_idx",  64'(i0), 64'd1);
        chk("bp_a_data", d0, 64'h11);
        out_ready = 1'b0; step();
        chk("bp_s1_valid", 64'(v0), 64'd1);
        chk("bp_s1_idx",   64'(i0), 64'd1);
        chk("bp_s1_data",  d0, 64'h11);
        chk("bp_s1_last",  64'(l0), 64'd0);
        step();
        chk("bp_s2_idx",   64'(i0), 64'd1);
        chk("bp_s2_data",  d0, 64'h11);
        chk("bp_s2_pc",    p0, 64'h300);
        out_ready = 1'b1; step();
        chk("bp_b_idx", 64'(i0), 64'd2);

        // FIFO overflow: 5 writes while stalled
        out_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            wr(5'(10 + n), 64'hA0 + 64'(n));
            if (n == 3) chk("ovf_not_yet", 64'(po0), 64'd0);
        end
        chk("ovf_set", 64'(po0), 64'd1);
        chk("ovf_held_idx", 64'(i0), 64'd2);
        out_ready = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 60 && !done; n++) begin
            step();
            if (!b0) done = 1'b1;
        end
        chk("ovf_drain_done", 64'(done), 64'd1);
        chk("ovf_sticky", 64'(po0), 64'd1);
        commit(64'h400);
        for (int k = 0; k < 10; k++) step();
        for (int n = 0; n < 5; n++) begin
            chk("ovf_idx", 64'(i0), 64'(10 + n));
            chk("ovf_data", d0, (n < 4) ? 64'hA0 + 64'(n) : 64'd0);
            step();
        end

        // Mid-SCAN reset
        commit(64'h500);
        chk("mid_drop", 64'(dc0), 64'd1);
        chk("mid_valid_pre", 64'(v0), 64'd1);
        rst_n = 1'b0;
        step();
        chk("mid_rst_valid", 64'(v0), 64'd0);
        chk("mid_rst_busy",  64'(b0), 64'd0);
        chk("mid_rst_drop",  64'(dc0), 64'd0);
        chk("mid_rst_ovf",   64'(po0), 64'd0);
        chk("mid_rst_valid1", 64'(v1), 64'd0);
        rst_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
